pico_axi_addr_arbiter: RTL and testbench

// Round-robin arbiter for one AXI address channel (AR or AW; one instance each) sharing one MIG master port among
// C_NUM_SLAVE_PORTS requesters. Prepends the winning port index to the transaction ID (MS bits), so the response

---
 rtl/pico_axi_addr_arbiter_if.sv | 48 ++++
 rtl/pico_axi_addr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_pico_axi_addr_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pico_axi_addr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pico_axi_addr_arbiter_if
// Description : Requester-side and MIG-side AXI address channel bundle for
//               the address arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface pico_axi_addr_arbiter_if #(
    parameter int C_NUM_SLAVE_PORTS     = 4,
    parameter int C_AXI_SLAVE_ID_WIDTH  = 8,
    parameter int C_AXI_MASTER_ID_WIDTH = 10,
    parameter int C_AXI_ADDR_WIDTH      = 33
);
    // Requester side, port i occupies slice [i*W +: W] of each flattened field
    logic [C_NUM_SLAVE_PORTS-1:0]                        s_axi_valid;
    logic [C_NUM_SLAVE_PORTS-1:0]                        s_axi_ready;
    logic [C_NUM_SLAVE_PORTS*C_AXI_SLAVE_ID_WIDTH-1:0]   s_axi_id;
    logic [C_NUM_SLAVE_PORTS*C_AXI_ADDR_WIDTH-1:0]       s_axi_addr;
    logic [C_NUM_SLAVE_PORTS*8-1:0]                      s_axi_len;
    logic [C_NUM_SLAVE_PORTS*3-1:0]                      s_axi_size;
    logic [C_NUM_SLAVE_PORTS*2-1:0]                      s_axi_burst;

    // MIG side
    logic                                                m_axi_valid;
    logic                                                m_axi_ready;
    logic [C_AXI_MASTER_ID_WIDTH-1:0]                    m_axi_id;
    logic [C_AXI_ADDR_WIDTH-1:0]                         m_axi_addr;
    logic [7:0]                                          m_axi_len;
    logic [2:0]                                          m_axi_size;
    logic [1:0]                                          m_axi_burst;

    // Arbiter view: accepts requests, drives the MIG request
    modport master (
        input  s_axi_valid, s_axi_id, s_axi_addr, s_axi_len, s_axi_size, s_axi_burst,
        output s_axi_ready,
        output m_axi_valid, m_axi_id, m_axi_addr, m_axi_len, m_axi_size, m_axi_burst,
        input  m_axi_ready
    );

    // Environment view: requesters plus the MIG port
    modport slave (
        output s_axi_valid, s_axi_id, s_axi_addr, s_axi_len, s_axi_size, s_axi_burst,
        input  s_axi_ready,
        input  m_axi_valid, m_axi_id, m_axi_addr, m_axi_len, m_axi_size, m_axi_burst,
        output m_axi_ready
    );
endinterface
`default_nettype wire

// File: rtl/pico_axi_addr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pico_axi_addr_arbiter
// Description : Round-robin arbiter for one AXI address channel with a
//               registered output stage and an outstanding-transaction limit.
// Revision    : 1.0 - initial release
// ============================================================================
module pico_axi_addr_arbiter #(
    parameter int C_NUM_SLAVE_PORTS     = 4,
    parameter int C_AXI_SLAVE_ID_WIDTH  = 8,
    parameter int C_AXI_MASTER_ID_WIDTH = 10,
    parameter int C_AXI_ADDR_WIDTH      = 33,
    parameter int C_MAX_OUTSTANDING     = 16
) (
    input  wire                     clk,
    input  wire                     rst_n,
    pico_axi_addr_arbiter_if.master bus,
    input  wire                     resp_done,
    output logic [7:0]              outstanding
);

    localparam int         c_idx_w   = (C_NUM_SLAVE_PORTS > 1) ? $clog2(C_NUM_SLAVE_PORTS) : 1;
    localparam int         c_sid_w   = C_AXI_SLAVE_ID_WIDTH;
    localparam int         c_mid_w   = C_AXI_MASTER_ID_WIDTH;
    localparam int         c_addr_w  = C_AXI_ADDR_WIDTH;
    localparam logic [7:0] c_max_out = 8'(C_MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_idx_w-1:0]            r_last_grant;
    logic [c_idx_w-1:0]            w_grant_idx;
    logic                          w_grant_vld;
    logic                          w_credit_ok;
    logic                          w_load_en;
    logic                          w_s_hs;
    logic                          w_resp_dec;
    logic [C_NUM_SLAVE_PORTS-1:0]  w_s_ready;
    logic [7:0]                    r_outstanding;
    logic [7:0]                    w_outstanding_nxt;

    logic [c_sid_w-1:0]            w_sel_id;
    logic [c_addr_w-1:0]           w_sel_addr;
    logic [7:0]                    w_sel_len;
    logic [2:0]                    w_sel_size;
    logic [1:0]                    w_sel_burst;

    logic [c_mid_w-1:0]            r_m_id;
    logic [c_addr_w-1:0]           r_m_addr;
    logic [7:0]                    r_m_len;
    logic [2:0]                    r_m_size;
    logic [1:0]                    r_m_burst;

    function automatic logic [c_idx_w-1:0] wrap_idx(input logic [c_idx_w-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return c_idx_w'(sum % C_NUM_SLAVE_PORTS);
    endfunction

    // Rotating priority: search starts one past the previous winner
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 1; k <= C_NUM_SLAVE_PORTS; k++) begin
            if (!w_grant_vld && bus.s_axi_valid[wrap_idx(r_last_grant, k)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = wrap_idx(r_last_grant, k);
            end
        end
    end

    // A completion in the same cycle frees the slot the new request needs
    assign w_credit_ok = (r_outstanding < c_max_out) || resp_done;
    assign w_load_en   = rst_n && ((r_state == ST_EMPTY) || bus.m_axi_ready) && w_credit_ok;
    assign w_s_hs      = w_load_en && w_grant_vld;

    always_comb begin
        w_s_ready = '0;
        for (int i = 0; i < C_NUM_SLAVE_PORTS; i++) begin
            if (w_s_hs && (w_grant_idx == c_idx_w'(i))) begin
                w_s_ready[i] = 1'b1;
            end
        end
    end

    assign bus.s_axi_ready = w_s_ready;

    assign w_sel_id    = bus.s_axi_id   [int'(w_grant_idx) * c_sid_w  +: c_sid_w];
    assign w_sel_addr  = bus.s_axi_addr [int'(w_grant_idx) * c_addr_w +: c_addr_w];
    assign w_sel_len   = bus.s_axi_len  [int'(w_grant_idx) * 8        +: 8];
    assign w_sel_size  = bus.s_axi_size [int'(w_grant_idx) * 3        +: 3];
    assign w_sel_burst = bus.s_axi_burst[int'(w_grant_idx) * 2        +: 2];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_s_hs) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_s_hs) begin
                    w_state_nxt = ST_FULL;
                end else if (bus.m_axi_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A spurious completion with nothing outstanding is dropped
    assign w_resp_dec = resp_done && (r_outstanding != 8'd0);

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_s_hs && !w_resp_dec) begin
            w_outstanding_nxt = r_outstanding + 8'd1;
        end else if (!w_s_hs && w_resp_dec) begin
            w_outstanding_nxt = r_outstanding - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= 8'd0;
            r_last_grant  <= c_idx_w'(C_NUM_SLAVE_PORTS - 1);
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (w_s_hs) begin
                r_last_grant <= w_grant_idx;
            end
        end
    end

    // Output fields only move on an accepted request, so a stalled beat stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_id    <= '0;
            r_m_addr  <= '0;
            r_m_len   <= '0;
            r_m_size  <= '0;
            r_m_burst <= '0;
        end else if (w_s_hs) begin
            r_m_id    <= c_mid_w'({w_grant_idx, w_sel_id});
            r_m_addr  <= w_sel_addr;
            r_m_len   <= w_sel_len;
            r_m_size  <= w_sel_size;
            r_m_burst <= w_sel_burst;
        end
    end

    assign bus.m_axi_valid = (r_state == ST_FULL);
    assign bus.m_axi_id    = r_m_id;
    assign bus.m_axi_addr  = r_m_addr;
    assign bus.m_axi_len   = r_m_len;
    assign bus.m_axi_size  = r_m_size;
    assign bus.m_axi_burst = r_m_burst;
    assign outstanding     = r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_pico_axi_addr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pico_axi_addr_arbiter
// Description : Directed and random checks of the address arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pico_axi_addr_arbiter;
    localparam int N    = 4;
    localparam int SID  = 8;
    localparam int MID  = 10;
    localparam int AW   = 33;
    localparam int MAXO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       resp_done;
    logic       resp_done2;
    logic [7:0] outstanding;
    logic [7:0] outstanding2;

    int n_checks = 0;
    int n_err    = 0;

    pico_axi_addr_arbiter_if #(.C_NUM_SLAVE_PORTS(N), .C_AXI_SLAVE_ID_WIDTH(SID),
        .C_AXI_MASTER_ID_WIDTH(MID), .C_AXI_ADDR_WIDTH(AW)) bus ();
    pico_axi_addr_arbiter_if #(.C_NUM_SLAVE_PORTS(N), .C_AXI_SLAVE_ID_WIDTH(SID),
        .C_AXI_MASTER_ID_WIDTH(MID), .C_AXI_ADDR_WIDTH(AW)) bus2 ();

    pico_axi_addr_arbiter #(.C_NUM_SLAVE_PORTS(N), .C_AXI_SLAVE_ID_WIDTH(SID),
        .C_AXI_MASTER_ID_WIDTH(MID), .C_AXI_ADDR_WIDTH(AW), .C_MAX_OUTSTANDING(MAXO)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .resp_done(resp_done), .outstanding(outstanding));

    pico_axi_addr_arbiter #(.C_NUM_SLAVE_PORTS(N), .C_AXI_SLAVE_ID_WIDTH(SID),
        .C_AXI_MASTER_ID_WIDTH(MID), .C_AXI_ADDR_WIDTH(AW), .C_MAX_OUTSTANDING(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .resp_done(resp_done2), .outstanding(outstanding2));

    always #5 clk = ~clk;

    // Reference model state: what the MIG port should currently present
    int             m_last;
    int             m_cnt;
    bit             m_mv;
    logic [MID-1:0] m_id;
    logic [AW-1:0]  m_addr;
    logic [7:0]     m_len;
    logic [2:0]     m_size;
    logic [1:0]     m_burst;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_last = N - 1; m_cnt = 0; m_mv = 1'b0;
        m_id = '0; m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
    endfunction

    function automatic int model_pick();
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_last + k) % N;
            if (bus.s_axi_valid[p]) return p;
        end
        return -1;
    endfunction

    task automatic set_port(input int p, input logic [SID-1:0] id, input logic [AW-1:0] a,
                            input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        bus.s_axi_id[p*SID +: SID]  = id;
        bus.s_axi_addr[p*AW +: AW]  = a;
        bus.s_axi_len[p*8 +: 8]     = l;
        bus.s_axi_size[p*3 +: 3]    = s;
        bus.s_axi_burst[p*2 +: 2]   = b;
    endtask

    task automatic rand_port(input int p);
        set_port(p, SID'($urandom()), AW'({$urandom(), $urandom()}), 8'($urandom()),
                 3'($urandom()), 2'($urandom()));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
    endtask

    // Compare DUT to model, then advance one clock and update the model
    task automatic step(input string tag);
        int             g;
        bit             hs;
        logic [N-1:0]   er;
        #1;
        g  = model_pick();
        hs = rst_n && (!m_mv || bus.m_axi_ready) && (m_cnt < MAXO || resp_done) && (g >= 0);
        er = hs ? (N'(1) << g) : '0;
        check({tag, ".s_ready"},     64'(bus.s_axi_ready), 64'(er));
        check({tag, ".m_valid"},     64'(bus.m_axi_valid), 64'(m_mv));
        check({tag, ".m_id"},        64'(bus.m_axi_id),    64'(m_id));
        check({tag, ".m_fields"},
              64'({bus.m_axi_addr, bus.m_axi_len, bus.m_axi_size, bus.m_axi_burst}),
              64'({m_addr, m_len, m_size, m_burst}));
        check({tag, ".outstanding"}, 64'(outstanding),     64'(m_cnt));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (resp_done && m_cnt > 0) m_cnt--;
            if (hs) begin
                m_cnt++;
                m_mv    = 1'b1;
                m_last  = g;
                m_id    = MID'(g * (1 << SID) + int'(bus.s_axi_id[g*SID +: SID]));
                m_addr  = bus.s_axi_addr[g*AW +: AW];
                m_len   = bus.s_axi_len[g*8 +: 8];
                m_size  = bus.s_axi_size[g*3 +: 3];
                m_burst = bus.s_axi_burst[g*2 +: 2];
            end else if (bus.m_axi_ready) begin
                m_mv = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int            seq[5];
        logic [63:0]   snap_a;
        logic [MID-1:0] snap_id;

        seq = '{0, 1, 2, 3, 0};
        rst_n = 1'b1;
        resp_done = 1'b0; resp_done2 = 1'b0;
        bus.s_axi_valid = '0; bus.s_axi_id = '0; bus.s_axi_addr = '0; bus.s_axi_len = '0;
        bus.s_axi_size = '0; bus.s_axi_burst = '0; bus.m_axi_ready = 1'b0;
        bus2.s_axi_valid = '0; bus2.s_axi_id = '0; bus2.s_axi_addr = '0; bus2.s_axi_len = '0;
        bus2.s_axi_size = '0; bus2.s_axi_burst = '0; bus2.m_axi_ready = 1'b0;
        #1;
        apply_reset();
        @(negedge clk);

        // Reset held with random activity on every input
        for (int c = 0; c < 3; c++) begin
            bus.s_axi_valid = N'($urandom());
            for (int p = 0; p < N; p++) rand_port(p);
            bus.m_axi_ready = 1'($urandom());
            resp_done       = 1'($urandom());
            #1;
            check("rst.s_ready", 64'(bus.s_axi_ready), 64'd0);
            check("rst.m_valid", 64'(bus.m_axi_valid), 64'd0);
            check("rst.outstanding", 64'(outstanding), 64'd0);
            step("rst");
        end
        bus.s_axi_valid = '0; resp_done = 1'b0; bus.m_axi_ready = 1'b1;
        rst_n = 1'b1;
        repeat (2) step("idle");

        // Single requester on port 2
        bus.s_axi_valid = 4'b0100;
        set_port(2, 8'h05, 33'h1000, 8'd7, 3'd2, 2'd1);
        #1 check("p2.s_ready", 64'(bus.s_axi_ready), 64'h4);
        step("p2");
        bus.s_axi_valid = '0;
        #1;
        check("p2.m_valid", 64'(bus.m_axi_valid), 64'd1);
        check("p2.m_id", 64'(bus.m_axi_id), 64'h205);
        check("p2.m_addr", 64'(bus.m_axi_addr), 64'h1000);
        check("p2.m_len", 64'(bus.m_axi_len), 64'd7);
        check("p2.outstanding", 64'(outstanding), 64'd1);
        step("p2b");

        // Four contending requesters, back-to-back rotation from port 0
        apply_reset();
        step("rr_rst");
        rst_n = 1'b1;
        bus.s_axi_valid = 4'b1111;
        for (int p = 0; p < N; p++) set_port(p, SID'(8'h10 + p), AW'(33'h2000 + p * 64), 8'(p), 3'd3, 2'd1);
        bus.m_axi_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("rr");
            #1;
            check("rr.port", 64'(bus.m_axi_id[MID-1:SID]), 64'(seq[i]));
            check("rr.m_valid", 64'(bus.m_axi_valid), 64'd1);
        end

        // MIG stall while full: outputs hold, nothing accepted
        bus.m_axi_ready = 1'b0;
        snap_id = bus.m_axi_id;
        snap_a  = 64'({bus.m_axi_addr, bus.m_axi_len, bus.m_axi_size, bus.m_axi_burst});
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.s_ready", 64'(bus.s_axi_ready), 64'd0);
            check("stall.m_id", 64'(bus.m_axi_id), 64'(snap_id));
            check("stall.fields", 64'({bus.m_axi_addr, bus.m_axi_len, bus.m_axi_size, bus.m_axi_burst}), snap_a);
            step("stall");
        end
        bus.m_axi_ready = 1'b1;
        step("unstall");
        #1 check("unstall.port", 64'(bus.m_axi_id[MID-1:SID]), 64'd1);

        // Random traffic, first near the credit limit then draining
        for (int c = 0; c < 500; c++) begin
            for (int p = 0; p < N; p++) begin
                bus.s_axi_valid[p] = ($urandom_range(0, 99) < 60);
                rand_port(p);
            end
            bus.m_axi_ready = ($urandom_range(0, 99) < 70);
            resp_done = (m_cnt > 0) && ($urandom_range(0, 99) < ((c < 350) ? 35 : 85));
            step("rnd");
        end

        // Credit limit of 2 on the second instance
        bus.s_axi_valid = '0; bus.m_axi_ready = 1'b1; resp_done = 1'b0;
        bus2.m_axi_ready = 1'b1;
        bus2.s_axi_valid = 4'b0001;
        #1 check("cr.r1", 64'(bus2.s_axi_ready), 64'h1);
        @(posedge clk); @(negedge clk);
        #1 check("cr.r2", 64'(bus2.s_axi_ready), 64'h1);
        @(posedge clk); @(negedge clk);
        #1;
        check("cr.full_cnt", 64'(outstanding2), 64'd2);
        check("cr.stall", 64'(bus2.s_axi_ready), 64'd0);
        @(posedge clk); @(negedge clk);
        #1 check("cr.stall2", 64'(bus2.s_axi_ready), 64'd0);
        resp_done2 = 1'b1;
        #1 check("cr.resp_ready", 64'(bus2.s_axi_ready), 64'h1);
        @(posedge clk); @(negedge clk);
        resp_done2 = 1'b0;
        #1;
        check("cr.swap_cnt", 64'(outstanding2), 64'd2);
        check("cr.m_valid", 64'(bus2.m_axi_valid), 64'd1);
        bus2.s_axi_valid = '0;
        resp_done2 = 1'b1;
        @(posedge clk); @(negedge clk);
        #1 check("cr.dec1", 64'(outstanding2), 64'd1);
        @(posedge clk); @(negedge clk);
        #1 check("cr.dec0", 64'(outstanding2), 64'd0);
        @(posedge clk); @(negedge clk);
        #1 check("cr.floor", 64'(outstanding2), 64'd0);
        resp_done2 = 1'b0;

        // Asynchronous reset in the middle of a burst
        apply_reset();
        step("mid_rst0");
        rst_n = 1'b1;
        bus.s_axi_valid = 4'b1111;
        bus.m_axi_ready = 1'b1;
        for (int i = 0; i < 5; i++) step("burst");
        #1;
        check("burst.outstanding", 64'(outstanding), 64'd5);
        check("burst.m_valid", 64'(bus.m_axi_valid), 64'd1);
        #1;
        apply_reset();
        #1;
        check("async.m_valid", 64'(bus.m_axi_valid), 64'd0);
        check("async.outstanding", 64'(outstanding), 64'd0);
        check("async.m_id", 64'(bus.m_axi_id), 64'd0);
        @(negedge clk);
        step("async");
        rst_n = 1'b1;
        #1 check("async.first", 64'(bus.s_axi_ready), 64'h1);
        step("post");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
